// File: rtl/avalon_mms_responder.sv
// Avalon-MM slave backed by on-chip word RAM: init stall, per-command wait states,
// fixed-latency pipelined reads, bounded outstanding reads. Optional AVS_RAND_WAIT_EN: LFSR wait counts.
module avalon_mms_responder #(
  parameter int P_ADDR_NBIT   = 24,
  parameter int P_DATA_NBIT   = 32,
  parameter int P_MEM_NBIT    = 8,
  parameter int P_INIT_CYCLES = 16,
  parameter int P_WAIT_CYCLES = 1,
  parameter int P_RD_LATENCY  = 3,
  parameter int P_MAX_PEND    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [P_ADDR_NBIT-1:0]               avalon_address,
  input  logic [P_DATA_NBIT/8-1:0]             avalon_byteenable_n,
  input  logic                                 avalon_chipselect,
  input  logic [P_DATA_NBIT-1:0]               avalon_writedata,
  input  logic                                 avalon_read_n,
  input  logic                                 avalon_write_n,
  output logic [P_DATA_NBIT-1:0]               avalon_readdata,
  output logic                                 avalon_readdatavalid,
  output logic                                 avalon_waitrequest,
  output logic                                 init_done,
  output logic [$clog2(P_MAX_PEND+1)-1:0]      pend_cnt
);

  localparam int NBYTE  = P_DATA_NBIT / 8;
  localparam int DEPTH  = 1 << P_MEM_NBIT;
  localparam int PEND_W = $clog2(P_MAX_PEND + 1);
  localparam int INIT_W = $clog2(P_INIT_CYCLES + 1);
  localparam int WCNT_W = ($clog2(P_WAIT_CYCLES + 1) > 2) ? $clog2(P_WAIT_CYCLES + 1) : 2;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_STALL, ST_GRANT} state_t;

  state_t                 state;
  logic [INIT_W-1:0]      init_cnt;
  logic [WCNT_W-1:0]      wait_cnt;
  logic [WCNT_W-1:0]      wait_val;
  logic                   cmd, is_rd, throttle, accept, rd_acc, wr_acc;
  logic [P_MEM_NBIT-1:0]  addr_idx;
  logic                   unused_addr_hi;

  logic [P_DATA_NBIT-1:0] mem [DEPTH];
  logic [P_RD_LATENCY-1:0] vld;
  logic [P_RD_LATENCY-1:0] feed_v;
  logic [P_DATA_NBIT-1:0] dpipe  [P_RD_LATENCY];
  logic [P_DATA_NBIT-1:0] feed_d [P_RD_LATENCY];

  assign addr_idx       = avalon_address[P_MEM_NBIT-1:0];
  assign unused_addr_hi = ^avalon_address[P_ADDR_NBIT-1:P_MEM_NBIT];

  assign cmd      = avalon_chipselect & (~avalon_read_n | ~avalon_write_n);
  assign is_rd    = ~avalon_read_n & avalon_write_n;
  assign throttle = cmd & is_rd & (pend_cnt == PEND_W'(P_MAX_PEND));

`ifdef AVS_RAND_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign wait_val = WCNT_W'(lfsr[1:0]);
`else
  assign wait_val = WCNT_W'(P_WAIT_CYCLES);
`endif

  always_comb begin
    avalon_waitrequest = 1'b1;
    case (state)
      ST_INIT:  avalon_waitrequest = 1'b1;
      ST_IDLE:  avalon_waitrequest = cmd & (throttle | (wait_val != '0));
      ST_STALL: avalon_waitrequest = 1'b1;
      ST_GRANT: avalon_waitrequest = throttle;
      default:  avalon_waitrequest = 1'b1;
    endcase
  end

  assign accept = cmd & ~avalon_waitrequest;
  assign rd_acc = accept & is_rd;
  assign wr_acc = accept & ~avalon_write_n;

  // The IDLE cycle that sees cmd is itself the first wait cycle, so STALL covers the remaining
  // wait_val-1 cycles and hands over to GRANT as the count leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_W'(P_INIT_CYCLES - 1)) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        ST_IDLE: begin
          if (cmd && !throttle && wait_val != '0) begin
            wait_cnt <= wait_val - WCNT_W'(1);
            state    <= (wait_val == WCNT_W'(1)) ? ST_GRANT : ST_STALL;
          end
        end
        ST_STALL: begin
          wait_cnt <= wait_cnt - WCNT_W'(1);
          if (!cmd)                         state <= ST_IDLE;
          else if (wait_cnt <= WCNT_W'(1))  state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (!throttle) state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned b = 0; b < NBYTE; b++) begin
        if (!avalon_byteenable_n[b]) mem[addr_idx][b*8 +: 8] <= avalon_writedata[b*8 +: 8];
      end
    end
  end

  // Each stage loads only when a token enters it, so the last stage doubles as the held readdata.
  always_comb begin
    feed_v[0] = rd_acc;
    feed_d[0] = mem[addr_idx];
    for (int unsigned i = 1; i < P_RD_LATENCY; i++) begin
      feed_v[i] = vld[i-1];
      feed_d[i] = dpipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < P_RD_LATENCY; i++) dpipe[i] <= '0;
    end else begin
      vld <= feed_v;
      for (int unsigned i = 0; i < P_RD_LATENCY; i++) begin
        if (feed_v[i]) dpipe[i] <= feed_d[i];
      end
    end
  end

  assign avalon_readdatavalid = vld[P_RD_LATENCY-1];
  assign avalon_readdata      = dpipe[P_RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      case ({rd_acc, avalon_readdatavalid})
        2'b10:   pend_cnt <= pend_cnt + PEND_W'(1);
        2'b01:   pend_cnt <= pend_cnt - PEND_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mms_responder.sv
// Directed bench for avalon_mms_responder: instance 0 uses one wait state, instance 1 is zero-wait.
module tb_avalon_mms_responder;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] addr    [2];
  logic [BW-1:0] be_n    [2];
  logic          cs      [2];
  logic [DW-1:0] wdata   [2];
  logic          read_n  [2];
  logic          write_n [2];
  logic [DW-1:0] rdata   [2];
  logic          rdv     [2];
  logic          wreq    [2];
  logic          idone   [2];
  logic [1:0]    pend    [2];

  avalon_mms_responder #(.P_WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .avalon_address(addr[0]), .avalon_byteenable_n(be_n[0]), .avalon_chipselect(cs[0]),
    .avalon_writedata(wdata[0]), .avalon_read_n(read_n[0]), .avalon_write_n(write_n[0]),
    .avalon_readdata(rdata[0]), .avalon_readdatavalid(rdv[0]), .avalon_waitrequest(wreq[0]),
    .init_done(idone[0]), .pend_cnt(pend[0])
  );

  avalon_mms_responder #(.P_WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .avalon_address(addr[1]), .avalon_byteenable_n(be_n[1]), .avalon_chipselect(cs[1]),
    .avalon_writedata(wdata[1]), .avalon_read_n(read_n[1]), .avalon_write_n(write_n[1]),
    .avalon_readdata(rdata[1]), .avalon_readdatavalid(rdv[1]), .avalon_waitrequest(wreq[1]),
    .init_done(idone[1]), .pend_cnt(pend[1])
  );

  // Each return is logged with the edge at which the master samples it.
  int            qe0 [$];
  int            qe1 [$];
  logic [DW-1:0] qd0 [$];
  logic [DW-1:0] qd1 [$];

  always @(negedge clk) begin
    if (rdv[0] === 1'b1) begin qe0.push_back(cyc + 1); qd0.push_back(rdata[0]); end
    if (rdv[1] === 1'b1) begin qe1.push_back(cyc + 1); qd1.push_back(rdata[1]); end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle(input int s);
    cs[s] = 1'b0; read_n[s] = 1'b1; write_n[s] = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge, with that edge's number.
  task automatic issue(input int s, input bit wr, input bit rd, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d, output int acc);
    cs[s] = 1'b1; read_n[s] = ~rd; write_n[s] = ~wr;
    addr[s] = a; be_n[s] = be; wdata[s] = d;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (wreq[s] === 1'b0) begin
        @(posedge clk); #1; acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("issue_timeout", 64'd0, 64'd1);
    else @(negedge clk);
  endtask

  task automatic get_rd(input int s, output int e, output logic [DW-1:0] d);
    e = -1; d = '0;
    for (int n = 0; n < 64; n++) begin
      if (s == 0 && qe0.size() > 0) begin e = qe0.pop_front(); d = qd0.pop_front(); break; end
      if (s == 1 && qe1.size() > 0) begin e = qe1.pop_front(); d = qd1.pop_front(); break; end
      @(negedge clk);
    end
    if (e < 0) check("rd_timeout", 64'd0, 64'd1);
  endtask

  int            acc, acc2, r, e, stalls, hi;
  int            a1, a2, a3, a4;
  logic [DW-1:0] d;

  initial begin
    for (int s = 0; s < 2; s++) begin
      drive_idle(s); addr[s] = '0; be_n[s] = '0; wdata[s] = '0;
    end
    repeat (3) @(negedge clk);

    check("rst_wreq",  64'(wreq[0]),  64'd1);
    check("rst_rdv",   64'(rdv[0]),   64'd0);
    check("rst_rdata", 64'(rdata[0]), 64'd0);
    check("rst_idone", 64'(idone[0]), 64'd0);
    check("rst_pend",  64'(pend[0]),  64'd0);

    // Read held from reset release: 16 init cycles plus one wait cycle before acceptance.
    cs[0] = 1'b1; read_n[0] = 1'b0; write_n[0] = 1'b1; addr[0] = '0;
    rst_n = 1'b1;
    r = cyc; stalls = 0; acc = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (cyc - r == 15) check("init_done_lo", 64'(idone[0]), 64'd0);
      if (cyc - r == 16) check("init_done_hi", 64'(idone[0]), 64'd1);
      if (wreq[0] === 1'b0) begin
        @(posedge clk); #1; acc = cyc;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    check("init_stalls", 64'(stalls), 64'd17);
    check("init_acc_edge", 64'(acc - r), 64'd18);
    @(negedge clk);
    drive_idle(0);
    get_rd(0, e, d);
    check("init_rd_lat", 64'(e - acc), 64'd3);

    issue(0, 1, 0, 24'h000005, 4'b0000, 32'hDEADBEEF, acc);
    issue(0, 1, 0, 24'h000005, 4'b1100, 32'h11223344, acc);
    issue(0, 0, 1, 24'h000005, 4'b0000, 32'h0, acc);
    drive_idle(0);
    check("rd5_pend", 64'(pend[0]), 64'd1);
    get_rd(0, e, d);
    check("rd5_data", 64'(d), 64'hDEAD3344);
    check("rd5_lat", 64'(e - acc), 64'd3);
    repeat (3) @(negedge clk);
    check("rd5_single", 64'(qe0.size()), 64'd0);
    check("rd5_pend_done", 64'(pend[0]), 64'd0);

    issue(0, 1, 0, 24'h000103, 4'b0000, 32'hA5A5A5A5, acc);
    issue(0, 0, 1, 24'h000003, 4'b0000, 32'h0, acc);
    drive_idle(0);
    get_rd(0, e, d);
    check("alias_data", 64'(d), 64'hA5A5A5A5);

    issue(0, 1, 1, 24'h000007, 4'b0000, 32'h12345678, acc);
    drive_idle(0);
    repeat (8) @(negedge clk);
    check("proto_no_rdv", 64'(qe0.size()), 64'd0);
    check("proto_pend", 64'(pend[0]), 64'd0);
    issue(0, 0, 1, 24'h000007, 4'b0000, 32'h0, acc);
    drive_idle(0);
    get_rd(0, e, d);
    check("proto_data", 64'(d), 64'h12345678);

    // Zero-wait instance: write immediately followed by a read of the same word.
    issue(1, 1, 0, 24'h000020, 4'b0000, 32'hC0FFEE00, acc);
    issue(1, 0, 1, 24'h000020, 4'b0000, 32'h0, acc2);
    drive_idle(1);
    check("raw_b2b", 64'(acc2 - acc), 64'd1);
    get_rd(1, e, d);
    check("raw_data", 64'(d), 64'hC0FFEE00);
    check("raw_lat", 64'(e - acc2), 64'd3);

    for (int i = 0; i < 4; i++) issue(1, 1, 0, AW'(32'h10 + i), 4'b0000, 32'hB0000000 + i, acc);
    issue(1, 0, 1, 24'h000010, 4'b0000, 32'h0, a1);
    issue(1, 0, 1, 24'h000011, 4'b0000, 32'h0, a2);
    check("thr_pend2", 64'(pend[1]), 64'd2);
    issue(1, 0, 1, 24'h000012, 4'b0000, 32'h0, a3);
    issue(1, 0, 1, 24'h000013, 4'b0000, 32'h0, a4);
    drive_idle(1);
    check("thr_a2", 64'(a2 - a1), 64'd1);
    check("thr_a3", 64'(a3 - a1), 64'd4);
    check("thr_a4", 64'(a4 - a1), 64'd5);
    get_rd(1, e, d); check("thr_e1", 64'(e - a1), 64'd3); check("thr_d1", 64'(d), 64'hB0000000);
    get_rd(1, e, d); check("thr_e2", 64'(e - a1), 64'd4); check("thr_d2", 64'(d), 64'hB0000001);
    get_rd(1, e, d); check("thr_e3", 64'(e - a1), 64'd7); check("thr_d3", 64'(d), 64'hB0000002);
    get_rd(1, e, d); check("thr_e4", 64'(e - a1), 64'd8); check("thr_d4", 64'(d), 64'hB0000003);

    issue(0, 0, 1, 24'h000005, 4'b0000, 32'h0, acc);
    drive_idle(0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_pend",  64'(pend[0]),  64'd0);
    check("mid_rst_wreq",  64'(wreq[0]),  64'd1);
    check("mid_rst_idone", 64'(idone[0]), 64'd0);
    rst_n = 1'b1;
    hi = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (wreq[0] === 1'b0) break;
      hi++;
      @(negedge clk);
    end
    check("mid_rst_init", 64'(hi), 64'd16);
    repeat (8) @(negedge clk);
    check("mid_rst_no_rdv", 64'(qe0.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
